// File: rtl/alu_handshake.sv
// alu_handshake: registered ALU with valid/ready handshake on both sides.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiply (op 1000).
module alu_handshake #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             slt;
  logic             accept;
  logic             is_mul;

`ifdef ALU_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mlier_q, mlier_d;
  logic [WIDTH-1:0] acc_step;

  assign is_mul   = (alu_op == OP_MUL);
  assign acc_step = mlier_q[0] ? acc_q + mcand_q : acc_q;
  assign busy     = (state_q == BUSY);
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  assign shamt = b[SHW-1:0];
  assign slt   = $signed(a) < $signed(b);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      default: alu_res = '0;
    endcase
  end

  assign in_ready  = (state_q == IDLE) ||
                     (state_q == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign zero      = zero_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_MUL_EN
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mlier_d  = mlier_q;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          if (is_mul) begin
            state_d = BUSY;
`ifdef ALU_MUL_EN
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = a;
            mlier_d = b;
`endif
          end else begin
            state_d  = HOLD;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end else if (state_q == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        // last step folds straight into the result register
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mlier_d = mlier_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = HOLD;
          result_d = acc_step;
          zero_d   = (acc_step == '0);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mlier_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_MUL_EN
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mlier_q  <= mlier_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_handshake.sv
// tb_alu_handshake: directed vectors, a transaction-level reference model
// and a per-cycle compare process for alu_handshake.
module tb_alu_handshake;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  always #5 clk = ~clk;

  alu_handshake #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    longint       rdy;
  } ent_t;

  ent_t   q[$];
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;

  logic         pin_en = 1'b0;
  string        pin_name;
  logic [W-1:0] pin_res;
  logic         pin_zero, pin_ov, pin_busy, pin_ir;

  function automatic logic [W-1:0] ref_alu(
    input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned sh;
    sh = y % W;
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b1100: return ~(x | y);
      4'b0111: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'b0011: return x << sh;
      4'b0100: return x >> sh;
      4'b1000: return MUL_ON ? x * y : '0;
      default: return '0;
    endcase
  endfunction

  function automatic bit exp_valid();
    return q.size() > 0 && cyc >= q[0].rdy;
  endfunction

  function automatic bit exp_busy();
    return q.size() > 0 && cyc < q[0].rdy;
  endfunction

  function automatic bit exp_ready();
    return q.size() == 0 || (exp_valid() && out_ready);
  endfunction

  task automatic step();
    bit v, r;
    @(posedge clk);
    if (!reset) begin
      v = exp_valid();
      r = exp_ready();
      if (v && out_ready) void'(q.pop_front());
      if (in_valid && r)
        q.push_back('{ref_alu(alu_op, a, b),
          cyc + ((MUL_ON && alu_op == 4'b1000) ? W : 1)});
    end
    cyc = cyc + 1;
    #1;
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    alu_op = op;
    a = x;
    b = y;
  endtask

  task automatic pin(input string n, input logic [W-1:0] r,
                     input logic z, input logic ov,
                     input logic bs, input logic ir);
    pin_name = n;
    pin_res = r;
    pin_zero = z;
    pin_ov = ov;
    pin_busy = bs;
    pin_ir = ir;
    pin_en = 1'b1;
    @(negedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  always @(negedge clk) begin : compare
    bit ev;
    ev = exp_valid();
    cmp("out_valid", W'(out_valid), W'(ev));
    cmp("in_ready", W'(in_ready), W'(exp_ready()));
    cmp("busy", W'(busy), W'(exp_busy()));
    if (ev) begin
      cmp("result", result, q[0].res);
      cmp("zero", W'(zero), W'(q[0].res == '0));
    end
    if (pin_en) begin
      cmp({pin_name, ".ov"}, W'(out_valid), W'(pin_ov));
      cmp({pin_name, ".busy"}, W'(busy), W'(pin_busy));
      cmp({pin_name, ".ir"}, W'(in_ready), W'(pin_ir));
      if (pin_ov) begin
        cmp({pin_name, ".res"}, result, pin_res);
        cmp({pin_name, ".zero"}, W'(zero), W'(pin_zero));
      end
    end
  end

  task automatic cmp(input string n, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_op = '0;
    a = '0;
    b = '0;
    step();
    step();
    pin("reset", '0, 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    step();

    // back-to-back ADD then SUB, no bubble
    drive(4'b0010, 5, 7);
    step();
    drive(4'b0110, 9, 9);
    pin("add", 12, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    pin("sub", 0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();

    drive(4'b0111, '1, 1);
    step();
    drive(4'b0100, 64'h8000_0000_0000_0000, 63);
    pin("slt", 1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(4'b0011, 1, 64'h41);
    pin("srl", 1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(4'b1100, 64'hF0F0, 64'h0F00);
    pin("sll", 2, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    pin("nor", 64'hFFFF_FFFF_FFFF_000F, 1'b0, 1'b1, 1'b0, 1'b1);
    step();

    // backpressure with next op already presented
    out_ready = 1'b0;
    drive(4'b0001, 64'hF0, 64'h0F);
    step();
    drive(4'b0000, 64'hF0, 64'h0F);
    for (int i = 0; i < 3; i++) begin
      pin("hold", 64'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    pin("release", 64'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    pin("and", 0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();

    drive(4'b0101, 3, 4);
    step();
    drive(4'b1000, 64'hFFFF_FFFF, 3);
`ifdef ALU_MUL_EN
    pin("op5", 0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    pin("mul0", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (W - 1) step();
    pin("mulN", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    pin("mul", 64'h2_FFFF_FFFD, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(4'b1000, 5, 6);
    step();
    in_valid = 1'b0;
    repeat (19) step();
`else
    pin("op5", 0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    pin("op8", 0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    out_ready = 1'b0;
    drive(4'b0010, 20, 22);
    step();
    in_valid = 1'b0;
    step();
`endif
    // reset mid-operation abandons it
    reset = 1'b1;
    q.delete();
    pin("rst_mid", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    drive(4'b0010, 1, 1);
    step();
    in_valid = 1'b0;
    pin("add11", 2, 1'b0, 1'b1, 1'b0, 1'b1);
    step();

    // streaming mix with toggling out_ready
    for (int i = 0; i < 24; i++) begin
      logic [3:0] ops [9];
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100,
              4'b0111, 4'b0011, 4'b0100, 4'b1111};
      out_ready = (i % 3) != 1;
      if (!(in_valid && !in_ready))
        drive(ops[i % 9], {$urandom, $urandom}, {$urandom, $urandom});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_handshake.md
# alu_handshake

Parametrised, registered ALU with a valid/ready handshake on input and output. It extends the datapath ALU op set (AND/OR/ADD/SUB/NOR) with SLT, SLL, SRL and an optional multi-cycle shift-add multiply. It sits between the execute-stage operand muxes and writeback, so a long operation can stall the pipeline through `in_ready`. `zero` is registered with `result`, and an undefined opcode gives a defined 0 instead of a held value.

## Interface
- `WIDTH`, default 64: operand and result width, ≥ 8, power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width. Derived; do not override.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: operands and op are valid.
- `in_ready` output 1: block can accept an operation this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B; `b[SHW-1:0]` is the shift amount.
- `alu_op` input 4: operation select.
- `out_valid` output 1: `result` and `zero` are valid.
- `out_ready` input 1: consumer takes the result this cycle.
- `result` output WIDTH: registered result.
- `zero` output 1: registered flag, `result == 0`.
- `busy` output 1: a multiply is in progress.

## Operation
- Op encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (modulo 2^WIDTH)
  - 0110 SUB (modulo 2^WIDTH)
  - 1100 NOR
  - 0111 SLT (signed compare; result is 1 or 0)
  - 0011 SLL by `b[SHW-1:0]`
  - 0100 SRL (logical) by `b[SHW-1:0]`
  - 1000 MUL (low WIDTH bits of the product)
- Any other op gives result 0 and zero 1.
- Accept occurs on a rising edge with `in_valid && in_ready`. `a`, `b` and `alu_op` are captured at accept; later input changes have no effect.
- `in_ready = (state==IDLE) || (state==HOLD && out_ready)`. This is combinational from the state and `out_ready`.
- States:
  - IDLE: `out_valid` = 0.
  - BUSY: multiply iterating; `busy` = 1, `in_ready` = 0.
  - HOLD: `out_valid` = 1; `result` and `zero` are held stable until `out_ready`.
- Transitions:
  - IDLE or consumed HOLD, accept of a non-MUL op → HOLD, result loaded.
  - IDLE or consumed HOLD, accept of MUL → BUSY, counter cleared.
  - HOLD with `out_ready` and no accept → IDLE.
  - HOLD with `!out_ready` → HOLD.
  - BUSY with counter == WIDTH-1 → HOLD.
- Multiply iteration, one step per cycle:
  - If multiplier LSB is 1, acc += multiplicand.
  - Multiplicand <<= 1, multiplier >>= 1.
  - Counter is SHW bits and increments each cycle in BUSY.
- Reset values: state IDLE, `out_valid` 0, `in_ready` 1, `busy` 0, `result` 0, `zero` 1, counter 0, accumulator 0.
- Reset asserted mid-multiply abandons the operation; no result is produced.

## Timing
- Single-cycle ops: accept at edge N, then `out_valid`=1 and `result` valid after edge N. Latency is 1.
- MUL: accept at edge N, then `busy`=1 after edge N through edge N+WIDTH-1, and `out_valid`=1 after edge N+WIDTH. Latency is WIDTH.
- Full throughput for non-MUL ops when `out_ready` is held high: one accept and one result per cycle.
- Backpressure: while HOLD and `!out_ready`, `in_ready`=0 and outputs are frozen.
- Simultaneous consume and accept in HOLD: the old result leaves, the new op loads, and `out_valid` stays 1.
- `in_valid` while `in_ready`=0 is ignored. The producer must hold its inputs.

## Configuration
- `ALU_MUL_EN` defined: MUL (1000) is implemented as above, and BUSY, the counter and the accumulator exist.
- `ALU_MUL_EN` undefined: no multiply hardware is built. 1000 is treated as an undefined op (result 0, zero 1, latency 1), `busy` is tied 0, and BUSY is unreachable.

## Test plan
- ADD a=5, b=7, `out_ready`=1 → after 1 cycle: `out_valid`=1, result=12, zero=0. Then SUB a=9, b=9 on the next cycle → result=0, zero=1, with no bubble.
- SLT a=0xFFFF_FFFF_FFFF_FFFF, b=1 → result=1. SRL a=0x8000_0000_0000_0000, b=63 → result=1. SLL a=1, b=0x41 (amount 1) → result=2.
- MUL a=0xFFFF_FFFF, b=3 (`ALU_MUL_EN`) → `in_ready`=0 and `busy`=1 for 64 cycles, then result=0x2_FFFF_FFFD, zero=0.
- Backpressure: OR a=0xF0, b=0x0F with `out_ready`=0 for 3 cycles → result=0xFF held and `in_ready`=0. Then `out_ready`=1 with a new AND 0xF0&0x0F presented → accepted that same edge, and the next result is 0 with zero=1.
- Reset pulsed at cycle 20 of a MUL → immediately `busy`=0 and `out_valid`=0, and `in_ready`=1 after reset deasserts. The next ADD 1+1 returns 2.
- Op 0101, and op 1000 with `ALU_MUL_EN` undefined → result=0, zero=1, latency 1, `busy` never asserted.
